// File: rtl/lenet_pkg.sv
// Shared LeNet constants and arithmetic helpers used by the pooling stages.
package lenet_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int MAX_DATA_W     = 32;

  localparam int C1_LEN = 28;
  localparam int S2_LEN = 14;
  localparam int C3_LEN = 10;
  localparam int S4_LEN = 5;

  typedef logic signed [MAX_DATA_W-1:0] wide_t;

  // Operands are sign-extended into wide_t by the caller, so one helper serves every DATA_W.
  function automatic wide_t smax(input wide_t a, input wide_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool2x2_stage_if.sv
// Element stream into a 2x2 pooling stage and the pooled result stream out of it.
interface pool2x2_stage_if
  import lenet_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  // in_en is a valid with no ready: the stage accepts one element on every cycle in_en is high.
  // out_valid is likewise a one-cycle strobe; the consumer must take out_data when it is high.
  logic                     in_en;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic [5:0]               out_row;
  logic [5:0]               out_col;
  logic                     frame_done;

  modport master (
    output in_en, in_data,
    input  out_valid, out_data, out_row, out_col, frame_done
  );

  modport slave (
    input  in_en, in_data,
    output out_valid, out_data, out_row, out_col, frame_done
  );

endinterface

// File: rtl/pool_rowbuf.sv
// Row buffer holding one horizontal pair-maximum per output column of the pooled map.
module pool_rowbuf #(
  parameter int DEPTH  = 14,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [DEPTH];

  // Contents need no reset: every entry is rewritten on an even row before an odd row reads it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wr_data;
    end
  end

  assign rd_data = mem[idx];

endmodule

// File: rtl/pool2x2_stage.sv
// 2x2 stride-2 signed max pooling over a row-major element stream with gapped enables.
module pool2x2_stage
  import lenet_pkg::*;
#(
  parameter int IN_COLS = C1_LEN,
  parameter int IN_ROWS = C1_LEN,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input logic            clk,
  input logic            reset,
  pool2x2_stage_if.slave bus
);

  localparam int         HALF_COLS = IN_COLS / 2;
  localparam int         IDX_W     = (HALF_COLS > 1) ? $clog2(HALF_COLS) : 1;
  localparam logic [5:0] LAST_COL  = 6'(IN_COLS - 1);
  localparam logic [5:0] LAST_ROW  = 6'(IN_ROWS - 1);

  if ((IN_COLS % 2) != 0 || (IN_ROWS % 2) != 0 || IN_COLS < 2 || IN_ROWS < 2 ||
      IN_COLS > 64 || IN_ROWS > 64 || DATA_W > MAX_DATA_W) begin : g_bad_params
    $error("pool2x2_stage: IN_COLS/IN_ROWS must be even and in 2..64, DATA_W at most 32");
  end

  logic [5:0]               col_cnt;
  logic [5:0]               row_cnt;
  logic signed [DATA_W-1:0] pair_q;
  logic signed [DATA_W-1:0] hmax;
  logic signed [DATA_W-1:0] rowbuf_rd;
  logic signed [DATA_W-1:0] result;
  logic                     rowbuf_we;
  logic                     col_last;
  logic                     row_last;

  assign col_last  = (col_cnt == LAST_COL);
  assign row_last  = (row_cnt == LAST_ROW);
  assign rowbuf_we = bus.in_en & col_cnt[0] & ~row_cnt[0];

  assign hmax   = DATA_W'(smax(wide_t'(pair_q), wide_t'(bus.in_data)));
  assign result = DATA_W'(smax(wide_t'(rowbuf_rd), wide_t'(hmax)));

  pool_rowbuf #(
    .DEPTH  (HALF_COLS),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_rowbuf (
    .clk     (clk),
    .we      (rowbuf_we),
    .idx     (col_cnt[IDX_W:1]),
    .wr_data (hmax),
    .rd_data (rowbuf_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_cnt        <= '0;
      row_cnt        <= '0;
      pair_q         <= '0;
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.out_data   <= '0;
      bus.out_row    <= '0;
      bus.out_col    <= '0;
    end else begin
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      if (bus.in_en) begin
        if (!col_cnt[0]) begin
          pair_q <= bus.in_data;
        end else if (row_cnt[0]) begin
          // Bottom-right element of a window: the pooled result is complete this cycle.
          bus.out_valid  <= 1'b1;
          bus.out_data   <= result;
          bus.out_row    <= {1'b0, row_cnt[5:1]};
          bus.out_col    <= {1'b0, col_cnt[5:1]};
          bus.frame_done <= col_last & row_last;
        end
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? 6'd0 : row_cnt + 6'd1;
        end else begin
          col_cnt <= col_cnt + 6'd1;
        end
      end
    end
  end

endmodule
